// File: rtl/adv7393_pkg.sv
// ADV7393 configuration types shared by the sequencer and its payload register.
//   adv7393_reg_entry_t : one register-table entry {sub_addr, data}
//   adv7393_cmd_t       : I2C write command payload {dev_addr, sub_addr, data}
//   adv7393_state_e     : sequencer FSM states
//   DEF_CONFIG          : default register table (SD composite output bring-up)
package adv7393_pkg;

  typedef struct packed {
    logic [7:0] sub_addr;
    logic [7:0] data;
  } adv7393_reg_entry_t;

  typedef struct packed {
    logic [6:0] dev_addr;
    logic [7:0] sub_addr;
    logic [7:0] data;
  } adv7393_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PWR,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } adv7393_state_e;

  localparam int unsigned DEF_REG_COUNT = 16;

  // Software reset first, then DAC power-up, SD mode and filter setup.
  localparam adv7393_reg_entry_t DEF_CONFIG [DEF_REG_COUNT] = '{
    '{sub_addr: 8'h17, data: 8'h02},
    '{sub_addr: 8'h00, data: 8'h1C},
    '{sub_addr: 8'h01, data: 8'h00},
    '{sub_addr: 8'h80, data: 8'h10},
    '{sub_addr: 8'h82, data: 8'hC9},
    '{sub_addr: 8'h84, data: 8'h00},
    '{sub_addr: 8'h86, data: 8'h00},
    '{sub_addr: 8'h87, data: 8'h00},
    '{sub_addr: 8'h88, data: 8'h00},
    '{sub_addr: 8'h8A, data: 8'h0C},
    '{sub_addr: 8'h8B, data: 8'h00},
    '{sub_addr: 8'h8C, data: 8'h1F},
    '{sub_addr: 8'h8D, data: 8'h7C},
    '{sub_addr: 8'h8E, data: 8'hF0},
    '{sub_addr: 8'h8F, data: 8'h21},
    '{sub_addr: 8'h02, data: 8'h20}
  };

  // Counter/index width that never collapses to zero bits.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adv7393_cfg_sequencer_payload.sv
// Command payload register: captures {DEV_ADDR, entry} when load is high and
// holds it until the next load, keeping the command stable across back-pressure.
//   clk, rst_n : clock, async active-low reset
//   load       : capture strobe (asserted on entry into ISSUE)
//   entry      : register-table entry to send
//   cmd        : registered command payload
module adv7393_cfg_sequencer_payload
  import adv7393_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h2A
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  adv7393_reg_entry_t entry,
  output adv7393_cmd_t       cmd
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd <= '0;
    end else if (load) begin
      cmd <= '{dev_addr: DEV_ADDR, sub_addr: entry.sub_addr, data: entry.data};
    end
  end

endmodule

// File: rtl/adv7393_cfg_sequencer.sv
// ADV7393 configuration sequencer: after a start request and a power-up wait,
// writes each register-table entry through a cmd/rsp I2C master interface,
// retrying NACKed entries up to MAX_RETRY times before aborting.
//   clk, rst_n          : clock, async active-low reset
//   reg_table           : REG_COUNT entries {sub_addr, data}
//   start               : one-cycle sequence request (ignored unless idle)
//   busy / done / error : status (busy level, done pulse, sticky error level)
//   err_index           : failing entry index, valid while error is high
//   cmd_valid/cmd_ready : write command handshake
//   cmd_dev_addr/cmd_sub_addr/cmd_data : command payload
//   rsp_valid/rsp_nack  : completion strobe and NACK qualifier
module adv7393_cfg_sequencer
  import adv7393_pkg::*;
#(
  parameter int unsigned REG_COUNT      = 16,
  parameter logic [6:0]  DEV_ADDR       = 7'h2A,
  parameter int unsigned STARTUP_CYCLES = 1000,
  parameter int unsigned MAX_RETRY      = 3,
  localparam int unsigned IDX_W         = safe_clog2(REG_COUNT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  adv7393_reg_entry_t reg_table [REG_COUNT],
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [IDX_W-1:0]   err_index,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [6:0]         cmd_dev_addr,
  output logic [7:0]         cmd_sub_addr,
  output logic [7:0]         cmd_data,
  input  logic               rsp_valid,
  input  logic               rsp_nack
);

  localparam int unsigned CNT_W = safe_clog2(STARTUP_CYCLES);
  localparam int unsigned RTY_W = safe_clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((STARTUP_CYCLES == 0) ? 0 : STARTUP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(REG_COUNT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

  adv7393_state_e     state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [RTY_W-1:0]   retry, retry_d;
  logic               error_d;
  logic [IDX_W-1:0]   err_index_d;
  logic               load_c;
  adv7393_cmd_t       cmd;

  // Next-state, counters and error latch.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    idx_d       = idx;
    retry_d     = retry;
    error_d     = error;
    err_index_d = err_index;
    load_c      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_d       = '0;
          idx_d       = '0;
          retry_d     = '0;
          error_d     = 1'b0;
          err_index_d = '0;
          if (STARTUP_CYCLES == 0) begin
            state_d = ST_ISSUE;
            load_c  = 1'b1;
          end else begin
            state_d = ST_WAIT_PWR;
          end
        end
      end

      ST_WAIT_PWR: begin
        if (cnt == CNT_LAST) begin
          state_d = ST_ISSUE;
          load_c  = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      ST_ISSUE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = ST_WAIT_RSP;
        end
      end

      ST_WAIT_RSP: begin
        if (rsp_valid) begin
          if (!rsp_nack) begin
            state_d = ST_NEXT;
          end else if (retry < RTY_MAX) begin
            retry_d = retry + RTY_W'(1);
            state_d = ST_ISSUE;
            load_c  = 1'b1;
          end else begin
            state_d     = ST_ERROR;
            error_d     = 1'b1;
            err_index_d = idx;
          end
        end
      end

      ST_NEXT: begin
        if (idx == IDX_LAST) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx + IDX_W'(1);
          retry_d = '0;
          state_d = ST_ISSUE;
          load_c  = 1'b1;
        end
      end

      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and status registers; status outputs are decoded from the next state
  // so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      retry     <= '0;
      error     <= 1'b0;
      err_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_valid <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      retry     <= retry_d;
      error     <= error_d;
      err_index <= err_index_d;
      busy      <= (state_d == ST_WAIT_PWR) || (state_d == ST_ISSUE) ||
                   (state_d == ST_WAIT_RSP) || (state_d == ST_NEXT);
      done      <= (state_d == ST_DONE);
      cmd_valid <= (state_d == ST_ISSUE);
    end
  end

  // Table entry is sampled with the index it is about to be issued under.
  adv7393_cfg_sequencer_payload #(
    .DEV_ADDR (DEV_ADDR)
  ) u_payload (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_c),
    .entry (reg_table[idx_d]),
    .cmd   (cmd)
  );

  assign cmd_dev_addr = cmd.dev_addr;
  assign cmd_sub_addr = cmd.sub_addr;
  assign cmd_data     = cmd.data;

endmodule

// File: tb/tb_adv7393_cfg_sequencer.sv
module tb_adv7393_cfg_sequencer;
  import adv7393_pkg::*;

  localparam int unsigned NREG = 4;
  localparam logic [6:0]  DEV  = 7'h2A;

  logic clk;
  logic rst_n;
  logic start;
  logic cmd_ready;
  logic rsp_valid;
  logic rsp_nack;
  logic busy, done, error, cmd_valid;
  logic [1:0] err_index;
  logic [6:0] cmd_dev_addr;
  logic [7:0] cmd_sub_addr, cmd_data;
  adv7393_reg_entry_t tbl [NREG];

  int n_tests = 0;
  int n_fail  = 0;

  adv7393_cfg_sequencer #(
    .REG_COUNT      (NREG),
    .DEV_ADDR       (DEV),
    .STARTUP_CYCLES (10),
    .MAX_RETRY      (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_table    (tbl),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_index    (err_index),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_dev_addr (cmd_dev_addr),
    .cmd_sub_addr (cmd_sub_addr),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_nack     (rsp_nack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Acts as the I2C master: accepts commands (optionally after a ready delay),
  // answers one cycle later with ACK/NACK per the plan, and optionally pulses
  // reset while entry rst_entry is waiting for its response.
  task automatic run_seq(input int nack_entry, input int nack_cnt, input int ready_delay,
                         input bit poke, input int rst_entry,
                         output int issues, output int dones, output int first_cv,
                         output logic err_seen, output logic [1:0] err_idx_seen);
    int exp_idx  = 0;
    int nacks    = 0;
    int wait_cnt = 0;
    int cyc      = 0;
    bit prev_valid = 1'b0;
    bit prev_ready = 1'b0;
    bit finished   = 1'b0;
    issues = 0; dones = 0; first_cv = -1; err_seen = 1'b0; err_idx_seen = '0;
    @(negedge clk);
    start = 1'b1;
    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start     = poke && (cyc == 3 || cyc == 20);
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      if (cyc == 1) begin
        check("busy_on_start", 64'(busy), 64'(1));
        check("error_cleared_on_start", 64'(error), 64'(0));
      end
      if (done) dones++;
      if (cmd_valid && first_cv < 0) first_cv = cyc;
      if (prev_valid && prev_ready) begin
        issues++;
        cmd_ready = 1'b0;
        wait_cnt  = 0;
        if (exp_idx == rst_entry) begin
          rst_n = 1'b0;
          @(negedge clk);
          check("outputs_zero_in_reset",
                64'({busy, done, error, cmd_valid, err_index, cmd_dev_addr, cmd_sub_addr, cmd_data}),
                64'(0));
          rst_n = 1'b1;
          repeat (3) begin
            @(negedge clk);
            check("idle_after_reset", 64'({busy, done, cmd_valid}), 64'(0));
          end
          finished = 1'b1;
        end else if (exp_idx == nack_entry && nacks < nack_cnt) begin
          rsp_valid = 1'b1;
          rsp_nack  = 1'b1;
          nacks++;
        end else begin
          rsp_valid = 1'b1;
          exp_idx++;
        end
      end else if (cmd_valid) begin
        if (exp_idx < int'(NREG))
          check("payload", 64'({cmd_dev_addr, cmd_sub_addr, cmd_data}), 64'({DEV, tbl[exp_idx]}));
        else
          check("extra_command", 64'(cmd_valid), 64'(0));
        if (wait_cnt >= ready_delay) begin
          cmd_ready = 1'b1;
        end else begin
          wait_cnt++;
          if (poke) rsp_valid = 1'b1;
        end
      end
      prev_valid = cmd_valid;
      prev_ready = cmd_ready;
      if (!finished && cyc > 1 && !busy) begin
        finished     = 1'b1;
        err_seen     = error;
        err_idx_seen = err_index;
      end
    end
    start     = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
    check("seq_terminated", 64'(finished), 64'(1));
  endtask

  typedef struct {
    int   nack_entry;
    int   nack_cnt;
    int   ready_delay;
    bit   poke;
    int   exp_issues;
    int   exp_done;
    logic exp_err;
    logic [1:0] exp_err_idx;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int   issues, dones, first_cv;
    logic err_seen;
    logic [1:0] err_idx_seen;

    for (int i = 0; i < int'(NREG); i++) begin
      tbl[i].sub_addr = 8'(8'h10 + i);
      tbl[i].data     = 8'(8'hA0 + 3 * i);
    end

    //            nack_e cnt dly poke issues done err idx
    vecs[0] = '{-1, 0, 0, 1'b0, 4, 1, 1'b0, 2'd0};  // clean run
    vecs[1] = '{ 2, 2, 0, 1'b0, 6, 1, 1'b0, 2'd0};  // entry 2 retried twice
    vecs[2] = '{ 1, 4, 0, 1'b0, 5, 0, 1'b1, 2'd1};  // entry 1 exhausts retries
    vecs[3] = '{-1, 0, 5, 1'b0, 4, 1, 1'b0, 2'd0};  // back-pressure 5 cycles
    vecs[4] = '{ 3, 3, 0, 1'b0, 7, 1, 1'b0, 2'd0};  // last entry, exactly MAX_RETRY nacks
    vecs[5] = '{ 0, 4, 0, 1'b0, 4, 0, 1'b1, 2'd0};  // first entry aborts
    vecs[6] = '{-1, 0, 2, 1'b1, 4, 1, 1'b0, 2'd0};  // start/rsp pokes while busy

    rst_n = 1'b0; start = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state",
          64'({busy, done, error, cmd_valid, err_index, cmd_dev_addr, cmd_sub_addr, cmd_data}),
          64'(0));
    rst_n = 1'b1;

    // Responses while idle must be ignored.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rsp_valid = 1'b1;
      rsp_nack  = k[0];
    end
    @(negedge clk);
    rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ignores_rsp", 64'({busy, done, error, cmd_valid}), 64'(0));

    for (int v = 0; v < 7; v++) begin
      run_seq(vecs[v].nack_entry, vecs[v].nack_cnt, vecs[v].ready_delay, vecs[v].poke, -1,
              issues, dones, first_cv, err_seen, err_idx_seen);
      repeat (3) begin
        @(negedge clk);
        if (done) dones++;
        if (cmd_valid) issues++;
      end
      check($sformatf("v%0d_first_cmd_latency", v), 64'(first_cv), 64'(11));
      check($sformatf("v%0d_issues", v), 64'(issues), 64'(vecs[v].exp_issues));
      check($sformatf("v%0d_done_pulses", v), 64'(dones), 64'(vecs[v].exp_done));
      check($sformatf("v%0d_error", v), 64'(err_seen), 64'(vecs[v].exp_err));
      if (vecs[v].exp_err) begin
        check($sformatf("v%0d_err_index", v), 64'(err_idx_seen), 64'(vecs[v].exp_err_idx));
        // Error must hold through idle responses until the next start.
        @(negedge clk); rsp_valid = 1'b1; rsp_nack = 1'b0;
        @(negedge clk); rsp_valid = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_error_held", v), 64'({error, err_index, busy}),
              64'({1'b1, vecs[v].exp_err_idx, 1'b0}));
      end
    end

    // Reset while entry 2 awaits its response, then a fresh full sequence.
    run_seq(-1, 0, 0, 1'b0, 2, issues, dones, first_cv, err_seen, err_idx_seen);
    check("rst_abort_issues", 64'(issues), 64'(3));
    check("rst_abort_no_done", 64'(dones), 64'(0));
    run_seq(-1, 0, 0, 1'b0, -1, issues, dones, first_cv, err_seen, err_idx_seen);
    check("post_rst_latency", 64'(first_cv), 64'(11));
    check("post_rst_issues", 64'(issues), 64'(4));
    check("post_rst_done", 64'(dones), 64'(1));
    check("post_rst_error", 64'(err_seen), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adv7393_cfg_sequencer.md
ADV7393_CFG_SEQUENCER -- requirements
Module: adv7393_cfg_sequencer

Interface
REQ-001 REG_COUNT, default 16: number of register-table entries written per sequence.
REQ-002 DEV_ADDR, default 7'h2A: 7-bit I2C device address of the ADV7393.
REQ-003 STARTUP_CYCLES, default 1000: clk cycles waited after start before the first write.
REQ-004 MAX_RETRY, default 3: NACK retries per entry before abort.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 reg_table  in  REG_COUNT x ADV7393RegEntry_t  {sub_addr[7:0], data[7:0]} per entry.
REQ-008 start  in  1  single-cycle request to run the full sequence.
REQ-009 busy  out  1  high from accepted start until DONE or ERROR is entered.
REQ-010 done  out  1  one-cycle pulse on successful completion.
REQ-011 error  out  1  level; set on abort, cleared by the next accepted start.
REQ-012 err_index  out  $clog2(REG_COUNT)  index of the failed entry, valid while error is high.
REQ-013 cmd_valid  out  1  write command valid to the I2C master.
REQ-014 cmd_ready  in  1  I2C master accepts the command.
REQ-015 cmd_dev_addr / cmd_sub_addr / cmd_data  out  7/8/8  command payload.
REQ-016 rsp_valid  in  1  one-cycle completion strobe from the I2C master.
REQ-017 rsp_nack  in  1  qualifies rsp_valid; 1 = slave NACK.

Function
REQ-018 FSM states: IDLE, WAIT_PWR, ISSUE, WAIT_RSP, NEXT, DONE, ERROR.
REQ-019 IDLE: start=1 -> WAIT_PWR; clears the startup counter, index, retry count and error.
REQ-020 WAIT_PWR: the counter increments each cycle; when it reaches STARTUP_CYCLES-1 -> ISSUE. STARTUP_CYCLES=0 -> direct to ISSUE.
REQ-021 ISSUE: cmd_valid=1 with payload {DEV_ADDR, reg_table[index]}; the payload stays stable while cmd_valid && !cmd_ready; cmd_valid&&cmd_ready -> WAIT_RSP, and cmd_valid drops the next cycle.
REQ-022 WAIT_RSP: rsp_valid&&!rsp_nack -> NEXT. rsp_valid&&rsp_nack with retry<MAX_RETRY -> retry+1, back to ISSUE with the same entry. Otherwise -> ERROR.
REQ-023 NEXT: index==REG_COUNT-1 -> DONE; else index+1, retry cleared -> ISSUE. The index never wraps.
REQ-024 DONE: done=1 for exactly one cycle -> IDLE.
REQ-025 ERROR: error=1 and err_index=index latched -> IDLE in the same transition; error holds until the next start.
REQ-026 start is ignored while busy=1.
REQ-027 rsp_valid outside WAIT_RSP is ignored.
REQ-028 Minimum latency per clean entry: ISSUE(1) + WAIT_RSP(>=1) + NEXT(1) cycles.
REQ-029 reg_table is sampled per entry at ISSUE entry and held in a payload register until the handshake completes.

Reset
REQ-030 reset low: FSM=IDLE; busy, done, error, cmd_valid=0; err_index, index, retry, counter, payload=0.
REQ-031 reset asserted mid-transaction aborts it immediately, with no completion pulse; after release, the block requires a new start.

Structure
REQ-032 ADV7393RegEntry_t, the FSM state enum and the default register table (def_config entries) live in adv7393_pkg.
REQ-033 A single sub-module, adv7393_i2c_master, sits behind the cmd/rsp interface; it is instantiated at the top level, not inside this block.

Verification
REQ-034 REG_COUNT=4, STARTUP_CYCLES=10, start, all ACK, cmd_ready=1 -> first cmd_valid 11 cycles after start; payloads are entries 0..3 in order, then done pulses once and busy falls.
REQ-035 Entry 2 NACKed twice, then ACK, MAX_RETRY=3 -> entry 2 is issued 3 times, then done=1 and error=0.
REQ-036 Entry 1 NACKed 4 times, MAX_RETRY=3 -> error=1, err_index=1, no done, no command for entries 2-3.
REQ-037 cmd_ready held low for 5 cycles in ISSUE -> cmd_valid and payload stay stable all 5 cycles, and exactly one handshake occurs.
REQ-038 reset pulsed low during WAIT_RSP of entry 2 -> all outputs are 0 next cycle; a new start restarts from entry 0 after the full startup delay.
REQ-039 start asserted during busy and rsp_valid asserted in IDLE -> no state change and no extra commands.
